// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full-subtractor slice, LSB first, IDLE/RUN/DONE control.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic [IDX_W-1:0] idx_reg;
    logic             br_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             br_next;
    logic             last_bit;

    assign bit_a    = a_reg[idx_reg];
    assign bit_b    = b_reg[idx_reg];
    assign bit_d    = bit_a ^ bit_b ^ br_reg;
    assign br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_reg);
    assign last_bit = (idx_reg == IDX_W'(WIDTH - 1));

    // Working word with the current result bit dropped into position idx.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_res
            assign res_next[gi] = (idx_reg == IDX_W'(gi)) ? bit_d : res_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            idx_reg   <= '0;
            br_reg    <= 1'b0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        br_reg  <= bin;
                        idx_reg <= '0;
                    end
                end
                RUN: begin
                    br_reg  <= br_next;
                    res_reg <= res_next;
                    idx_reg <= idx_reg + IDX_W'(1);
                    // Shadow outputs load on the final bit so they are valid throughout DONE.
                    if (last_bit) begin
                        diff_reg <= res_next;
                        bout_reg <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_reg  <= br_reg ^ br_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign diff = diff_reg;
    assign bout = bout_reg;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl (WIDTH=8); expected {ovf,bout,diff} queued at start.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf_v;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf;
    assign ovf_v = ovf;
`else
    assign ovf_v = 1'b0;
`endif

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .bout  (bout),
        .ovf   (ovf)
`else
        .bout  (bout)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] obs_mem[0:255];
    int           obs_cyc[0:255];
    int           done_cnt = 0;
    int           rd_ptr   = 0;
    int           cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture every done pulse with its cycle stamp.
    always @(negedge clk) begin
        if (done === 1'b1 && done_cnt < 256) begin
            obs_mem[done_cnt] <= {ovf_v, bout, diff};
            obs_cyc[done_cnt] <= cyc;
            done_cnt          <= done_cnt + 1;
        end
    end

    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mbin);
        int r;
        int sr;
        logic [W-1:0] d;
        logic bo;
        logic ov;
        r  = int'(ma) - int'(mb) - int'(mbin);
        d  = W'(r);
        bo = (r < 0);
        sr = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
`ifdef SERIAL_SUB_OVF_EN
        ov = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
`else
        ov = 1'b0;
`endif
        return {ov, bo, d};
    endfunction

    task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic tbin, input bit push);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        if (push) exp_q.push_back(model(ta, tb_v, tbin));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [W+1:0] obs;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = {ovf_v, bout, diff};
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: busy,done=%b required 00", {busy, done});
        end
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_data: ovf,bout,diff=%h required 0", obs);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [W+1:0] e;
        logic [W+1:0] obs;
        drive_start(8'h05, 8'h03, 1'b0, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== (c <= 9) || done !== (c == 9)) begin
                errors++;
                $display("FAIL basic_timing cycle %0d: busy=%b done=%b required busy=%b done=%b",
                         c, busy, done, (c <= 9), (c == 9));
            end
        end
        checks++;
        if (diff !== 8'h02) begin
            errors++;
            $display("FAIL basic_hold: diff=%h required 02", diff);
        end
        #1;
        checks++;
        if (done_cnt <= rd_ptr) begin
            errors++;
            $display("FAIL basic_result: no done seen, count=%0d", done_cnt);
        end else begin
            e   = exp_q.pop_front();
            obs = obs_mem[rd_ptr];
            rd_ptr++;
            if (obs !== e) begin
                errors++;
                $display("FAIL basic_result: got %h required %h", obs, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_borrow();
        logic [W-1:0] va[8];
        logic [W-1:0] vb[8];
        logic         vbin[8];
        logic [W+1:0] e;
        logic [W+1:0] obs;
        va[0] = 8'h03; vb[0] = 8'h05; vbin[0] = 1'b0;
        va[1] = 8'h00; vb[1] = 8'h00; vbin[1] = 1'b1;
        va[2] = 8'hFF; vb[2] = 8'hFF; vbin[2] = 1'b1;
        va[3] = 8'h80; vb[3] = 8'h7F; vbin[3] = 1'b0;
        for (int i = 4; i < 8; i++) begin
            va[i]   = W'($urandom_range(0, 255));
            vb[i]   = W'($urandom_range(0, 255));
            vbin[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            drive_start(va[i], vb[i], vbin[i], 1'b1);
            for (int k = 0; k < 40 && done_cnt <= rd_ptr; k++) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (done_cnt <= rd_ptr) begin
                errors++;
                $display("FAIL borrow_timeout vec %0d: no done", i);
            end else begin
                e   = exp_q.pop_front();
                obs = obs_mem[rd_ptr];
                rd_ptr++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL borrow_result %h-%h-%b: got %h required %h",
                             va[i], vb[i], vbin[i], obs, e);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignore_start();
        logic [W+1:0] e;
        logic [W+1:0] obs;
        drive_start(8'h10, 8'h01, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'h55;
        for (int k = 0; k < 40 && done_cnt <= rd_ptr; k++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (done_cnt <= rd_ptr) begin
            errors++;
            $display("FAIL ignore_timeout: no done");
        end else begin
            e   = exp_q.pop_front();
            obs = obs_mem[rd_ptr];
            rd_ptr++;
            if (obs !== e) begin
                errors++;
                $display("FAIL ignore_result: got %h required %h", obs, e);
            end
        end
        repeat (15) @(negedge clk);
        #1;
        checks++;
        if (done_cnt !== rd_ptr || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_second: done_count=%0d busy=%b required %0d and 0",
                     done_cnt, busy, rd_ptr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int           cnt0;
        logic [W+1:0] e;
        logic [W+1:0] obs;
        cnt0 = done_cnt;
        drive_start(8'h33, 8'h11, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs = {ovf_v, bout, diff};
        checks++;
        if ({busy, done} !== 2'b00 || obs !== '0) begin
            errors++;
            $display("FAIL abort_outputs: busy,done=%b ovf,bout,diff=%h required 00 and 0",
                     {busy, done}, obs);
        end
        repeat (12) @(negedge clk);
        #1;
        checks++;
        if (done_cnt !== cnt0) begin
            errors++;
            $display("FAIL abort_no_done: done_count=%0d required %0d", done_cnt, cnt0);
        end
        @(posedge clk);
        #1;
        drive_start(8'h09, 8'h04, 1'b0, 1'b1);
        for (int k = 0; k < 40 && done_cnt <= rd_ptr; k++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (done_cnt <= rd_ptr) begin
            errors++;
            $display("FAIL abort_restart_timeout: no done");
        end else begin
            e   = exp_q.pop_front();
            obs = obs_mem[rd_ptr];
            rd_ptr++;
            if (obs !== e) begin
                errors++;
                $display("FAIL abort_restart_result: got %h required %h", obs, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int           first;
        logic [W+1:0] e;
        logic [W+1:0] obs;
        first = rd_ptr;
        a = 8'h0A;
        b = 8'h0A;
        bin = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h0A, 8'h0A, 1'b0));
        start = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 40 && done_cnt < first + 3; k++) begin
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done_cnt <= rd_ptr) begin
                errors++;
                $display("FAIL b2b_timeout op %0d: no done", i);
            end else begin
                e   = exp_q.pop_front();
                obs = obs_mem[rd_ptr];
                if (obs !== e) begin
                    errors++;
                    $display("FAIL b2b_result op %0d: got %h required %h", i, obs, e);
                end
                if (i > 0) begin
                    checks++;
                    if (obs_cyc[rd_ptr] - obs_cyc[rd_ptr - 1] !== 10) begin
                        errors++;
                        $display("FAIL b2b_period op %0d: got %0d required 10",
                                 i, obs_cyc[rd_ptr] - obs_cyc[rd_ptr - 1]);
                    end
                end
                rd_ptr++;
            end
        end
        repeat (15) @(negedge clk);
        #1;
        checks++;
        if (done_cnt !== rd_ptr) begin
            errors++;
            $display("FAIL b2b_extra: done_count=%0d required %0d", done_cnt, rd_ptr);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] va[2];
        logic [W+1:0] e;
        logic [W+1:0] obs;
        va[0] = 8'h80;
        va[1] = 8'h7F;
        for (int i = 0; i < 2; i++) begin
            drive_start(va[i], 8'h01, 1'b0, 1'b1);
            for (int k = 0; k < 40 && done_cnt <= rd_ptr; k++) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (done_cnt <= rd_ptr) begin
                errors++;
                $display("FAIL ovf_timeout vec %0d: no done", i);
            end else begin
                e   = exp_q.pop_front();
                obs = obs_mem[rd_ptr];
                rd_ptr++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL ovf_result %h-01: got %h required %h", va[i], obs, e);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
